// File: rtl/seq_tx_101010.sv
// seq_tx_101010: serial pattern transmitter.
// Sends a WIDTH-bit pattern MSB first, repeat_n+1 frames back-to-back.
// The pattern is either the PATTERN parameter or pattern_in, and is captured
// when start is accepted. abort ends the transmission early.
// Optional feature macro: SEQ_TX_PARITY_EN. When it is defined, every frame
// is followed by one even-parity bit.
module seq_tx_101010 #(
    parameter int              WIDTH   = 6,
    parameter logic [WIDTH-1:0] PATTERN = 6'b101010,
    parameter int              CNT_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             load_sel,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             frame_end,
    output logic             done
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic [WIDTH-1:0]   pat_reg, pat_next;
    logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
    logic               last_bit;

    // The final data bit of the current frame is on x this cycle.
    assign last_bit = (bit_cnt_reg == BIT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: shift register, captured pattern, bit and frame counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg     <= '0;
            pat_reg       <= '0;
            bit_cnt_reg   <= '0;
            frame_cnt_reg <= '0;
        end else begin
            shift_reg     <= shift_next;
            pat_reg       <= pat_next;
            bit_cnt_reg   <= bit_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        pat_next       = pat_reg;
        bit_cnt_next   = bit_cnt_reg;
        frame_cnt_next = frame_cnt_reg;
        case (state_reg)
            IDLE: begin
                // abort has no effect here, so start wins when both are high.
                if (start) begin
                    pat_next       = load_sel ? pattern_in : PATTERN;
                    shift_next     = load_sel ? pattern_in : PATTERN;
                    bit_cnt_next   = '0;
                    frame_cnt_next = repeat_n;
                    state_next     = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = DONE;
                end else if (last_bit) begin
`ifdef SEQ_TX_PARITY_EN
                    state_next = PAR;
`else
                    // Frame complete: either finish or reload the captured pattern.
                    if (frame_cnt_reg == '0) begin
                        state_next = DONE;
                    end else begin
                        shift_next     = pat_reg;
                        bit_cnt_next   = '0;
                        frame_cnt_next = frame_cnt_reg - CNT_W'(1);
                    end
`endif
                end else begin
                    shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
                    bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: begin
                if (abort || frame_cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    shift_next     = pat_reg;
                    bit_cnt_next   = '0;
                    frame_cnt_next = frame_cnt_reg - CNT_W'(1);
                    state_next     = SHIFT;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the registered state and shift register.
    always_comb begin
        x         = 1'b0;
        valid     = 1'b0;
        busy      = 1'b0;
        frame_end = 1'b0;
        done      = 1'b0;
        case (state_reg)
            SHIFT: begin
                x     = shift_reg[WIDTH-1];
                valid = 1'b1;
                busy  = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                frame_end = 1'b0;
`else
                frame_end = last_bit;
`endif
            end
`ifdef SEQ_TX_PARITY_EN
            PAR: begin
                // Even parity: the frame plus this bit has an even number of ones.
                x         = ^pat_reg;
                valid     = 1'b1;
                busy      = 1'b1;
                frame_end = 1'b1;
            end
`endif
            DONE: begin
                done = 1'b1;
            end
            default: begin
                x = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_tx_101010.sv
// Directed bench for seq_tx_101010 (default parameters).
// Outputs are checked 1 time unit after each rising clock edge as the packed
// vector {x, valid, busy, frame_end, done}.
module tb_seq_tx_101010;

`ifdef SEQ_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       load_sel = 1'b0;
    logic [5:0] pattern_in = 6'd0;
    logic [3:0] repeat_n = 4'd0;
    logic       abort = 1'b0;
    logic       x, valid, busy, frame_end, done;

    int checks = 0;
    int errors = 0;

    seq_tx_101010 dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .load_sel   (load_sel),
        .pattern_in (pattern_in),
        .repeat_n   (repeat_n),
        .abort      (abort),
        .x          (x),
        .valid      (valid),
        .busy       (busy),
        .frame_end  (frame_end),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // exp = {x, valid, busy, frame_end, done}
    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {x, valid, busy, frame_end, done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed x/v/b/fe/d=%b expected %b", tag, obs, exp);
        end
    endtask

    // Checks one full frame starting at its first bit; returns one cycle
    // after the last emitted bit of the frame.
    task automatic run_frame(input string tag, input logic [5:0] pat);
        for (int i = 5; i >= 0; i--) begin
            chk($sformatf("%s_bit%0d", tag, i),
                {pat[i], 1'b1, 1'b1, ((i == 0) && !PAR_EN), 1'b0});
            step();
        end
        if (PAR_EN) begin
            chk($sformatf("%s_par", tag), {^pat, 1'b1, 1'b1, 1'b1, 1'b0});
            step();
        end
    endtask

    initial begin
        // Reset holds everything at zero with no clock edge required.
        #2;
        chk("reset_idle", 5'b00000);
        #10;
        reset = 1'b0;

        // Single frame of the built-in pattern, start at the first edge after reset.
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("single", 6'b101010);
        chk("single_done", 5'b00001);
        step();
        chk("single_idle", 5'b00000);

        // Three back-to-back frames.
        repeat_n = 4'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat_n = 4'd0;
        run_frame("rep0", 6'b101010);
        run_frame("rep1", 6'b101010);
        run_frame("rep2", 6'b101010);
        chk("rep_done", 5'b00001);
        step();
        chk("rep_idle", 5'b00000);

        // Runtime pattern; inputs change after capture and must not matter.
        load_sel = 1'b1;
        pattern_in = 6'b110001;
        repeat_n = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_bit5", 5'b11100);
        step();
        pattern_in = 6'd0;
        load_sel = 1'b0;
        repeat_n = 4'd0;
        chk("load_bit4", 5'b11100);
        step();
        for (int i = 3; i >= 0; i--) begin
            logic [5:0] p;
            p = 6'b110001;
            chk($sformatf("load_f0_bit%0d", i), {p[i], 1'b1, 1'b1, ((i == 0) && !PAR_EN), 1'b0});
            step();
        end
        if (PAR_EN) begin
            chk("load_f0_par", 5'b11110);
            step();
        end
        run_frame("load_f1", 6'b110001);
        chk("load_done", 5'b00001);
        step();
        chk("load_idle", 5'b00000);

        // Abort on the third bit; start held through DONE is ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("abort_b1", 5'b11100);
        step();
        chk("abort_b2", 5'b01100);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("abort_b3", 5'b11100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done", 5'b00001);
        start = 1'b1;
        step();
        chk("abort_idle", 5'b00000);
        // start and abort together in IDLE: start is accepted.
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        run_frame("after_abort", 6'b101010);
        chk("after_abort_done", 5'b00001);
        step();
        chk("after_abort_idle", 5'b00000);

        // Reset mid-frame: outputs clear at once, no done, clean restart.
        repeat_n = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("rst_mid_b4", 5'b01100);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_clear", 5'b00000);
        #1;
        reset = 1'b0;
        repeat_n = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame("rst_restart", 6'b101010);
        chk("rst_restart_done", 5'b00001);
        step();
        chk("rst_restart_idle", 5'b00000);

        // All-ones repeat count: 16 frames.
        repeat_n = 4'hF;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat_n = 4'd0;
        for (int f = 0; f < 16; f++) begin
            run_frame($sformatf("max_f%0d", f), 6'b101010);
        end
        chk("max_done", 5'b00001);
        step();
        chk("max_idle", 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_tx_101010.md
SEQ_TX_101010 -- requirements
Module: seq_tx_101010

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 6, giving the pattern length in bits (legal range 2 to 16).
REQ-002 The block SHALL have the parameter PATTERN, default 6'b101010, giving the built-in pattern, transmitted MSB first.
REQ-003 The block SHALL have the parameter CNT_W, default 4, giving the width of the repeat counter.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin a transmission, sampled only in IDLE.
REQ-007 The block SHALL have port load_sel, input, 1 bit: 1 selects pattern_in, 0 selects PATTERN; captured at start acceptance.
REQ-008 The block SHALL have port pattern_in, input, WIDTH bits: the runtime pattern.
REQ-009 The block SHALL have port repeat_n, input, CNT_W bits: frames to send minus one; captured at start acceptance.
REQ-010 The block SHALL have port abort, input, 1 bit: synchronous request to terminate the transmission.
REQ-011 The block SHALL have port x, output, 1 bit: registered serial data out.
REQ-012 The block SHALL have port valid, output, 1 bit: x carries a transmitted bit this cycle.
REQ-013 The block SHALL have port busy, output, 1 bit: a transmission is in progress.
REQ-014 The block SHALL have port frame_end, output, 1 bit: the current bit is the final bit of a frame.
REQ-015 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, SHIFT, PAR and DONE; PAR exists only when SEQ_TX_PARITY_EN is defined.
REQ-017 In IDLE with start=1 at a rising edge, the block SHALL load the shift register and frame counter and go to SHIFT; busy, valid and the first bit (MSB) SHALL appear in the next cycle.
REQ-018 In SHIFT, the block SHALL drive x from the shift-register MSB with valid=1 and busy=1, shifting left once per cycle.
REQ-019 Total frames sent SHALL be repeat_n+1; repeat_n=0 SHALL send exactly one frame, and the all-ones value SHALL send 2^CNT_W frames.
REQ-020 Frames SHALL be sent back-to-back with no idle gap: the first bit of frame k+1 immediately follows the last bit (or parity bit) of frame k.
REQ-021 Each subsequent frame SHALL reload the captured pattern, not the current inputs.
REQ-022 frame_end SHALL be 1 exactly on the last emitted bit of each frame.
REQ-023 After the final frame, the block SHALL enter DONE for one cycle with done=1, busy=0, valid=0 and x=0, then return to IDLE.
REQ-024 start SHALL be ignored in SHIFT, PAR and DONE; the earliest accepted restart is the cycle after DONE.
REQ-025 abort=1 sampled in SHIFT or PAR SHALL cause DONE in the next cycle, with no further bits sent and no frame_end pulse.
REQ-026 abort SHALL be ignored in IDLE and DONE; when start=1 and abort=1 together in IDLE, start SHALL be accepted.
REQ-027 In IDLE, x, valid, busy, frame_end and done SHALL all be 0.

Reset
REQ-028 While reset=1, the state SHALL be IDLE; x, valid, busy, frame_end and done SHALL be 0; and the shift register and counter SHALL be cleared, independent of clock.
REQ-029 Reset asserted mid-transmission SHALL abandon the transmission with no done pulse.
REQ-030 After reset deasserts, start SHALL be accepted at the first rising edge.

Configuration
REQ-031 With SEQ_TX_PARITY_EN defined, each frame SHALL be followed by one PAR cycle emitting the even-parity bit (XOR of the frame bits) with valid=1, and frame_end SHALL move to that parity bit.
REQ-032 With SEQ_TX_PARITY_EN undefined, the PAR state and parity logic SHALL be absent and frames SHALL be exactly WIDTH bits.

Verification
REQ-033 Scenario (default build): reset, then start=1 for 1 cycle with load_sel=0 and repeat_n=0. Required response: x=1,0,1,0,1,0 on cycles 1-6 with valid=1; frame_end on cycle 6; done on cycle 7; idle on cycle 8.
REQ-034 Scenario: repeat_n=2. Required response: 18 contiguous bits 101010 repeated three times, frame_end on cycles 6, 12 and 18, and done on cycle 19.
REQ-035 Scenario: load_sel=1 and pattern_in=6'b110001, with pattern_in changed to 0 mid-frame and repeat_n=1. Required response: 110001110001.
REQ-036 Scenario: abort=1 on cycle 3 of the frame. Required response: bits 1,0,1 sent, then done on cycle 4, with no frame_end.
REQ-037 Scenario: reset pulsed on cycle 4, then start on the next edge. Required response: outputs 0 immediately with no done, then a clean restart at the MSB.
REQ-038 Scenario (SEQ_TX_PARITY_EN defined, default pattern): required response 1,0,1,0,1,0,1, with frame_end on cycle 7 and done on cycle 8.
